// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-consumer bundle for uart_rx_fifo: push side from the UART Receiver,
// pop side and status toward the consuming logic.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]         rx_data;
  logic                     rx_parity_err;
  logic                     rx_valid;
  logic                     pop;
  logic                     clear_overrun;
  logic [WIDTH-1:0]         dout;
  logic                     dout_err;
  logic                     empty;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     overrun;

  modport master (
    output rx_data, rx_parity_err, rx_valid, pop, clear_overrun,
    input  dout, dout_err, empty, full, count, overrun
  );

  modport slave (
    input  rx_data, rx_parity_err, rx_valid, pop, clear_overrun,
    output dout, dout_err, empty, full, count, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART Receiver, with sticky overrun.
// Optional macro UART_RX_FIFO_DROP_BAD_EN: discard bytes flagged with a parity error.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input logic           CLOCK_125_p,
  input logic           reset,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            rx_valid_p1;
  logic            overrun_q;

  logic            push_req;
  logic            push_ok;
  logic            pop_ok;
  logic            ovf;
  logic            empty_w;
  logic            full_w;

  assign empty_w = (cnt == '0);
  assign full_w  = (cnt == CW'(DEPTH));

  // Rising edge of the receiver's level-valid is the push request.
`ifdef UART_RX_FIFO_DROP_BAD_EN
  assign push_req = bus.rx_valid & ~rx_valid_p1 & ~bus.rx_parity_err;
`else
  assign push_req = bus.rx_valid & ~rx_valid_p1;
`endif

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = bus.pop & ~empty_w;
  assign push_ok = push_req & (~full_w | pop_ok);
  assign ovf     = push_req & full_w & ~pop_ok;

  // ---- stage p1: control registers ----
  always_ff @(posedge CLOCK_125_p) begin
    if (reset) begin
      rx_valid_p1 <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      overrun_q   <= 1'b0;
    end else begin
      rx_valid_p1 <= bus.rx_valid;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (ovf)
        overrun_q <= 1'b1;
      else if (bus.clear_overrun)
        overrun_q <= 1'b0;
    end
  end

  // ---- stage p1: storage, left unreset ----
  always_ff @(posedge CLOCK_125_p) begin
    if (push_ok) mem[wr_ptr] <= {bus.rx_parity_err, bus.rx_data};
  end

  // ---- head output: combinational from storage, zero when empty ----
  assign bus.dout     = empty_w ? '0   : mem[rd_ptr][WIDTH-1:0];
  assign bus.dout_err = empty_w ? 1'b0 : mem[rd_ptr][WIDTH];
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.count    = cnt;
  assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scoreboard bench for uart_rx_fifo (DEPTH=8, WIDTH=8); honours
// UART_RX_FIFO_DROP_BAD_EN when the design is built with it.
module tb_uart_rx_fifo;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
`ifdef UART_RX_FIFO_DROP_BAD_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic CLOCK_125_p = 1'b0;
  logic reset;

  uart_rx_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLOCK_125_p (CLOCK_125_p),
    .reset       (reset),
    .bus         (bus)
  );

  always #4 CLOCK_125_p = ~CLOCK_125_p;

  int total = 0;
  int bad   = 0;
  logic [8:0] sb[$];
  logic       m_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_125_p);
    #1;
  endtask

  task automatic check_head(input string tag);
    logic [8:0] h;
    h = (sb.size() == 0) ? 9'd0 : sb[0];
    check({tag, ".dout"},    32'(bus.dout),     32'(h[7:0]));
    check({tag, ".err"},     32'(bus.dout_err), 32'(h[8]));
    check({tag, ".empty"},   32'(bus.empty),    32'(sb.size() == 0));
    check({tag, ".full"},    32'(bus.full),     32'(sb.size() == DEPTH));
    check({tag, ".count"},   32'(bus.count),    32'(sb.size()));
    check({tag, ".overrun"}, 32'(bus.overrun),  32'(m_ovr));
  endtask

  // Model the push decision for a push with no simultaneous pop.
  task automatic model_push(input logic [7:0] d, input logic e);
    if (!(DROP && e)) begin
      if (sb.size() < DEPTH) sb.push_back({e, d});
      else                   m_ovr = 1'b1;
    end
  endtask

  task automatic do_push(input string tag, input logic [7:0] d, input logic e);
    bus.rx_data       = d;
    bus.rx_parity_err = e;
    bus.rx_valid      = 1'b1;
    model_push(d, e);
    step();
    check_head(tag);
    bus.rx_valid = 1'b0;
    step();
  endtask

  task automatic do_pop(input string tag);
    logic [8:0] h;
    if (sb.size() != 0) begin
      h = sb.pop_front();
      check({tag, ".head"}, {23'd0, bus.dout_err, bus.dout}, 32'(h));
    end
    bus.pop = 1'b1;
    step();
    bus.pop = 1'b0;
    check_head(tag);
  endtask

  initial begin
    logic [8:0] h;
    reset             = 1'b1;
    bus.rx_data       = '0;
    bus.rx_parity_err = 1'b0;
    bus.rx_valid      = 1'b0;
    bus.pop           = 1'b0;
    bus.clear_overrun = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_head("reset");

    // Single push and pop.
    do_push("push_b3", 8'hB3, 1'b0);
    do_pop("pop_b3");

    // Level held high pushes once.
    bus.rx_data  = 8'h5A;
    bus.rx_valid = 1'b1;
    model_push(8'h5A, 1'b0);
    repeat (20) step();
    bus.rx_valid = 1'b0;
    step();
    check_head("hold_5a");
    do_pop("pop_5a");

    // Fill, overflow, drain across the pointer wrap.
    for (int i = 1; i <= 8; i++) do_push("fill", 8'(i), 1'b0);
    check(".full_after_fill", 32'(bus.full), 32'd1);
    do_push("ovf_09", 8'h09, 1'b0);
    check(".overrun_set", 32'(bus.overrun), 32'd1);
    for (int i = 1; i <= 8; i++) do_pop("drain");
    bus.clear_overrun = 1'b1;
    m_ovr = 1'b0;
    step();
    bus.clear_overrun = 1'b0;
    check_head("clear_ovr");

    // Full FIFO: push with simultaneous pop.
    for (int i = 0; i < 8; i++) do_push("fill2", 8'h11 + 8'(i), 1'b0);
    h = sb.pop_front();
    check("fullpp.head", {23'd0, bus.dout_err, bus.dout}, 32'(h));
    sb.push_back({1'b0, 8'h77});
    bus.rx_data  = 8'h77;
    bus.rx_valid = 1'b1;
    bus.pop      = 1'b1;
    step();
    bus.pop = 1'b0;
    check_head("fullpp");
    bus.rx_valid = 1'b0;
    step();
    for (int i = 0; i < 7; i++) do_pop("drain2");
    check("last_is_77", 32'(bus.dout), 32'h77);
    do_pop("pop_77");

    // Empty FIFO: pop alone, then push with pop.
    do_pop("empty_pop");
    sb.push_back({1'b0, 8'h3C});
    bus.rx_data  = 8'h3C;
    bus.rx_valid = 1'b1;
    bus.pop      = 1'b1;
    step();
    bus.pop      = 1'b0;
    bus.rx_valid = 1'b0;
    check_head("emptypp");
    step();
    do_pop("pop_3c");

    // Parity-error byte.
    do_push("bad_c3", 8'hC3, 1'b1);
    if (sb.size() != 0) do_pop("pop_c3");

    // Reset with three entries stored.
    do_push("r1", 8'hA1, 1'b0);
    do_push("r2", 8'hA2, 1'b0);
    do_push("r3", 8'hA3, 1'b0);
    reset = 1'b1;
    step();
    sb.delete();
    check_head("mid_reset");

    // rx_valid already high at reset release pushes on the first edge.
    bus.rx_data  = 8'hE5;
    bus.rx_valid = 1'b1;
    step();
    reset = 1'b0;
    sb.push_back({1'b0, 8'hE5});
    step();
    check_head("release_push");
    bus.rx_valid = 1'b0;
    step();
    do_pop("pop_e5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART `Receiver`. Captures each byte the receiver completes, together with its parity-check result, into a first-word-fall-through FIFO. Exposes a simple pop interface to the consuming logic (LED display, host logic), so back-to-back frames are not lost while the consumer is busy. Tracks overruns with a sticky flag.

## Interface

Parameters:
- `DEPTH`, 8, number of entries; power of two, ≥ 2.
- `WIDTH`, 8, data bits per entry; matches the receiver data byte.

Ports:
- `CLOCK_125_p`  input  1  system clock (125 MHz); all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `rx_data`  input  WIDTH  byte from `Receiver` (its `LEDR` value); sampled on the push event.
- `rx_parity_err`  input  1  high = parity mismatch for `rx_data`; sampled with it.
- `rx_valid`  input  1  level from receiver, high while a new byte is held; rising edge = push request.
- `pop`  input  1  consumer acknowledges the head entry.
- `clear_overrun`  input  1  clears the sticky overrun flag.
- `dout`  output  WIDTH  head entry data; 0 when empty.
- `dout_err`  output  1  parity-error bit of the head entry; 0 when empty.
- `empty`  output  1  no entries stored.
- `full`  output  1  DEPTH entries stored.
- `count`  output  $clog2(DEPTH)+1  number of stored entries.
- `overrun`  output  1  sticky: a push was discarded because the FIFO was full.

## Operation

- Edge detector: a register holds the previous `rx_valid`. push_req = `rx_valid` & ~prev. A level held high for N cycles produces exactly one push.
- Storage: a WIDTH+1-bit array of DEPTH entries holding {err, data}. Write and read pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0. `count` is kept as an explicit register.
- Push accepted when not full, or when full and pop is accepted in the same cycle. Data is written at wr_ptr, and wr_ptr increments.
- Pop accepted only when not empty. rd_ptr increments. Pop while empty is ignored: no pointer or count change.
- Push and pop in the same cycle, non-empty: both occur, and count is unchanged.
- Push and pop in the same cycle, empty: push only, and pop is ignored.
- Push when full without pop: the byte is discarded, pointers and count are unchanged, and `overrun` is set to 1.
- `overrun` is cleared by `clear_overrun`. If a new overrun occurs in the same cycle as the clear, set wins.
- `dout`/`dout_err` are combinational from array[rd_ptr] and gated to 0 when empty.

## Timing

- Reset (synchronous) values: pointers 0, count 0, prev `rx_valid` 0, `overrun` 0, `empty` 1, `full` 0, `dout` 0, `dout_err` 0. Array contents are don't-care.
- Reset asserted mid-operation discards all stored entries at that clock edge.
- An `rx_valid` high during reset release pushes on the first post-reset edge if prev = 0.
- Latency: `rx_valid` rises at edge k, push is registered at edge k. The byte is visible on `dout` with `empty` = 0 after edge k (one cycle from input rise to visible head).
- Pop at edge k: the next entry appears on `dout` after edge k. `count`, `empty`, and `full` update at the same edge as the push or pop that changes them.
- No combinational path from `rx_valid`/`rx_data` to any output.

## Configuration

- `UART_RX_FIFO_DROP_BAD_EN`
  - Defined: a push with `rx_parity_err` = 1 is silently discarded. It does not affect pointers, count, or `overrun`, and `dout_err` is therefore always 0.
  - Undefined (default): bad bytes are stored with `dout_err` = 1 for the consumer to inspect.

## Test plan

- Reset, then single push of 0xB3 with `rx_parity_err` = 0 → the cycle after the rise: `dout` = 0xB3, `dout_err` = 0, `count` = 1, `empty` = 0. Pop → `empty` = 1, `dout` = 0.
- Hold `rx_valid` high for 20 cycles with 0x5A → exactly one entry, `count` = 1.
- Push 0x01..0x08 (DEPTH = 8) → `full` = 1, `count` = 8. Push 0x09 → `overrun` = 1, count stays 8. Pop all 8 → order 0x01..0x08, with wrap exercised. Pulse `clear_overrun` → `overrun` = 0.
- Full FIFO, push 0x77 with simultaneous pop → head advances, count stays 8, `overrun` stays 0, and 0x77 is read last.
- Empty FIFO, pop alone → no change. Push 0x3C with simultaneous pop → `count` = 1, `dout` = 0x3C.
- Push 0xC3 with `rx_parity_err` = 1 → stored with `dout_err` = 1 (macro undefined), or not stored and `empty` stays 1 (`UART_RX_FIFO_DROP_BAD_EN` defined). Assert `reset` with 3 entries stored → next cycle `count` = 0, `empty` = 1.
